pipe_sequencer: RTL and testbench

PIPE_SEQUENCER -- requirements
Module: pipe_sequencer

---
 rtl/pipe_sequencer.sv | 121 ++++++++++++
 tb/tb_pipe_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_sequencer.sv
// Pipeline latch sequencer: turns hazard-unit flush/freeze requests into latch
// controls, stretches stalls over data-memory waits and drains a halt.
//
// state  | meaning
// -------+------------------------------------------------------------------
// RUN    | pipeline advancing; hazard requests applied directly
// DWAIT  | data access outstanding; pipeline fully frozen, flushes deferred
// DRAIN  | one cycle letting the mem/writeback latch capture the halt
// HALTED | processor stopped until reset
module pipe_sequencer (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic        dreq,
    input  logic        halt_mem,
    input  logic [3:0]  hu_flush,
    input  logic [3:0]  hu_freeze,
    output logic [3:0]  flush,
    output logic [3:0]  freeze,
    output logic        imemREN,
    output logic        halt,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] pend;
    logic [3:0] pend_nxt;
    logic       ihit_seen;
    logic       ihit_seen_nxt;
    logic [3:0] flush_raw;
    logic [3:0] freeze_raw;
    logic [3:0] run_flush;

    // An instruction fetch that never completed leaves a bubble for decode.
    assign run_flush = hu_flush | pend | {3'b000, ~ihit & ~ihit_seen};

    always_comb begin
        state_nxt     = state;
        pend_nxt      = pend;
        ihit_seen_nxt = ihit_seen;
        flush_raw     = 4'h0;
        freeze_raw    = 4'h0;
        case (state)
            RUN: begin
                if (!halt_mem && dreq && !dhit) begin
                    state_nxt     = DWAIT;
                    freeze_raw    = 4'hF;
                    pend_nxt      = pend | hu_flush;
                    ihit_seen_nxt = ihit_seen | ihit;
                end else begin
                    if (halt_mem) begin
                        state_nxt = DRAIN;
                    end
                    flush_raw     = run_flush;
                    freeze_raw    = hu_freeze;
                    pend_nxt      = 4'h0;
                    ihit_seen_nxt = 1'b0;
                end
            end
            DWAIT: begin
                if (dhit) begin
                    state_nxt     = RUN;
                    flush_raw     = run_flush;
                    freeze_raw    = hu_freeze;
                    pend_nxt      = 4'h0;
                    ihit_seen_nxt = 1'b0;
                end else begin
                    freeze_raw    = 4'hF;
                    pend_nxt      = pend | hu_flush;
                    ihit_seen_nxt = ihit_seen | ihit;
                end
            end
            DRAIN: begin
                state_nxt  = HALTED;
                freeze_raw = 4'b0111;
            end
            HALTED: begin
                freeze_raw = 4'hF;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    assign flush   = RST ? 4'h0 : flush_raw;
    assign freeze  = RST ? 4'h0 : (freeze_raw & ~flush_raw);
    assign imemREN = !RST && ((state == RUN) || (state == DWAIT)) && !ihit_seen;
    assign halt    = !RST && (state == HALTED);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= RUN;
            pend      <= 4'h0;
            ihit_seen <= 1'b0;
            stall_cnt <= 16'h0000;
            flush_cnt <= 16'h0000;
        end else begin
            state     <= state_nxt;
            pend      <= pend_nxt;
            ihit_seen <= ihit_seen_nxt;
            if ((freeze == 4'hF) && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if ((flush != 4'h0) && (flush_cnt != 16'hFFFF)) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_sequencer.sv
// Directed self-checking bench for pipe_sequencer: stall, deferred flush,
// fetch tracking, halt drain, flush/freeze priority, reset and saturation.
module tb_pipe_sequencer;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ihit, dhit, dreq, halt_mem;
    logic [3:0]  hu_flush, hu_freeze;
    logic [3:0]  flush, freeze;
    logic        imemREN, halt;
    logic [15:0] stall_cnt, flush_cnt;

    int checks = 0;
    int failures = 0;

    pipe_sequencer dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .dreq(dreq),
        .halt_mem(halt_mem), .hu_flush(hu_flush), .hu_freeze(hu_freeze),
        .flush(flush), .freeze(freeze), .imemREN(imemREN), .halt(halt),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle;
        ihit = 1'b1; dhit = 1'b0; dreq = 1'b0; halt_mem = 1'b0;
        hu_flush = 4'h0; hu_freeze = 4'h0;
    endtask

    task automatic apply_reset;
        idle();
        RST = 1'b1;
        tick();
        RST = 1'b0;
    endtask

    task automatic test_reset;
        RST = 1'b1;
        idle();
        tick();
        tick();
        dreq = 1'b1; hu_flush = 4'hF; hu_freeze = 4'hF; ihit = 1'b0;
        #1;
        checks++; if (flush !== 4'h0) begin failures++; $display("FAIL rst_flush got=%h exp=0", flush); end
        checks++; if (freeze !== 4'h0) begin failures++; $display("FAIL rst_freeze got=%h exp=0", freeze); end
        checks++; if (imemREN !== 1'b0 || halt !== 1'b0) begin failures++; $display("FAIL rst_ren_halt got=%b%b exp=00", imemREN, halt); end
        checks++; if (stall_cnt !== 16'h0 || flush_cnt !== 16'h0) begin failures++; $display("FAIL rst_cnt got=%h/%h exp=0/0", stall_cnt, flush_cnt); end
        idle();
        tick();
        RST = 1'b0;
        #1;
        checks++; if (imemREN !== 1'b1 || flush !== 4'h0 || freeze !== 4'h0) begin failures++; $display("FAIL post_rst_run got ren=%b fl=%h fr=%h exp 1/0/0", imemREN, flush, freeze); end
    endtask

    task automatic test_dwait_stall;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            dreq = 1'b1; dhit = 1'b0;
            #1;
            checks++; if (freeze !== 4'hF || flush !== 4'h0) begin failures++; $display("FAIL stall_frozen[%0d] got fr=%h fl=%h exp F/0", i, freeze, flush); end
            if (i == 0) begin
                checks++; if (imemREN !== 1'b1) begin failures++; $display("FAIL stall_ren0 got=%b exp=1", imemREN); end
            end
            tick();
        end
        dhit = 1'b1;
        #1;
        checks++; if (freeze !== 4'h0 || flush !== 4'h0) begin failures++; $display("FAIL stall_release got fr=%h fl=%h exp 0/0", freeze, flush); end
        tick();
        idle();
        #1;
        checks++; if (stall_cnt !== 16'd3) begin failures++; $display("FAIL stall_cnt got=%0d exp=3", stall_cnt); end
        checks++; if (flush_cnt !== 16'd0) begin failures++; $display("FAIL stall_flush_cnt got=%0d exp=0", flush_cnt); end
    endtask

    task automatic test_pend_flush;
        apply_reset();
        dreq = 1'b1; dhit = 1'b0;
        tick();
        hu_flush = 4'b0011;
        #1;
        checks++; if (flush !== 4'h0 || freeze !== 4'hF) begin failures++; $display("FAIL pend_hidden got fl=%h fr=%h exp 0/F", flush, freeze); end
        tick();
        hu_flush = 4'h0;
        #1;
        checks++; if (flush !== 4'h0) begin failures++; $display("FAIL pend_hidden2 got=%h exp=0", flush); end
        tick();
        dhit = 1'b1;
        #1;
        checks++; if (flush !== 4'b0011 || freeze !== 4'h0) begin failures++; $display("FAIL pend_release got fl=%b fr=%b exp 0011/0000", flush, freeze); end
        tick();
        idle();
        #1;
        checks++; if (flush !== 4'h0) begin failures++; $display("FAIL pend_cleared got=%h exp=0", flush); end
        checks++; if (flush_cnt !== 16'd1 || stall_cnt !== 16'd3) begin failures++; $display("FAIL pend_cnts got=%0d/%0d exp=1/3", flush_cnt, stall_cnt); end
    endtask

    task automatic test_ihit_seen;
        apply_reset();
        dreq = 1'b1; dhit = 1'b0; ihit = 1'b0;
        #1;
        checks++; if (imemREN !== 1'b1) begin failures++; $display("FAIL seen_ren_c0 got=%b exp=1", imemREN); end
        tick();
        ihit = 1'b1;
        #1;
        checks++; if (imemREN !== 1'b1) begin failures++; $display("FAIL seen_ren_c1 got=%b exp=1", imemREN); end
        tick();
        ihit = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (imemREN !== 1'b0) begin failures++; $display("FAIL seen_ren_wait[%0d] got=%b exp=0", i, imemREN); end
            tick();
        end
        dhit = 1'b1;
        #1;
        checks++; if (flush !== 4'h0) begin failures++; $display("FAIL seen_no_bubble got=%h exp=0", flush); end
        tick();
        dreq = 1'b0; dhit = 1'b0;
        #1;
        checks++; if (imemREN !== 1'b1 || flush !== 4'b0001) begin failures++; $display("FAIL seen_after ren=%b fl=%b exp 1/0001", imemREN, flush); end
        tick();
    endtask

    task automatic test_halt_and_saturation;
        apply_reset();
        halt_mem = 1'b1;
        tick();
        halt_mem = 1'b0;
        #1;
        checks++; if (freeze !== 4'b0111 || flush !== 4'h0 || halt !== 1'b0) begin failures++; $display("FAIL drain got fr=%b fl=%h halt=%b exp 0111/0/0", freeze, flush, halt); end
        tick();
        for (int i = 0; i < 12; i++) begin
            ihit = 1'($urandom_range(1)); dhit = 1'($urandom_range(1));
            dreq = 1'($urandom_range(1)); halt_mem = 1'($urandom_range(1));
            hu_flush = 4'($urandom_range(15)); hu_freeze = 4'($urandom_range(15));
            #1;
            checks++; if (halt !== 1'b1 || freeze !== 4'hF || flush !== 4'h0 || imemREN !== 1'b0) begin failures++; $display("FAIL halted[%0d] got h=%b fr=%h fl=%h ren=%b exp 1/F/0/0", i, halt, freeze, flush, imemREN); end
            tick();
        end
        idle();
        #1;
        checks++; if (stall_cnt !== 16'd12) begin failures++; $display("FAIL halted_cnt got=%0d exp=12", stall_cnt); end
        repeat (65530) tick();
        checks++; if (stall_cnt !== 16'hFFFF) begin failures++; $display("FAIL stall_sat got=%h exp=FFFF", stall_cnt); end
        repeat (5) tick();
        checks++; if (stall_cnt !== 16'hFFFF) begin failures++; $display("FAIL stall_sat_hold got=%h exp=FFFF", stall_cnt); end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        #1;
        checks++; if (halt !== 1'b0 || stall_cnt !== 16'h0 || imemREN !== 1'b1) begin failures++; $display("FAIL halt_reset got h=%b cnt=%h ren=%b exp 0/0/1", halt, stall_cnt, imemREN); end
    endtask

    task automatic test_flush_over_freeze;
        apply_reset();
        hu_flush = 4'b0001; hu_freeze = 4'b0001;
        #1;
        checks++; if (flush !== 4'b0001 || freeze !== 4'b0000) begin failures++; $display("FAIL prio_same got fl=%b fr=%b exp 0001/0000", flush, freeze); end
        hu_freeze = 4'b1111;
        #1;
        checks++; if (freeze !== 4'b1110) begin failures++; $display("FAIL prio_mask got=%b exp=1110", freeze); end
        tick();
        idle();
    endtask

    task automatic test_reset_mid_dwait;
        apply_reset();
        dreq = 1'b1; dhit = 1'b0; hu_flush = 4'b0100;
        tick();
        hu_flush = 4'b1000;
        tick();
        RST = 1'b1; hu_flush = 4'h0;
        #1;
        checks++; if (flush !== 4'h0 || freeze !== 4'h0) begin failures++; $display("FAIL midrst_out got fl=%h fr=%h exp 0/0", flush, freeze); end
        tick();
        RST = 1'b0; dreq = 1'b0;
        #1;
        checks++; if (flush !== 4'h0 || freeze !== 4'h0 || imemREN !== 1'b1) begin failures++; $display("FAIL midrst_run got fl=%b fr=%h ren=%b exp 0000/0/1", flush, freeze, imemREN); end
        checks++; if (stall_cnt !== 16'h0 || flush_cnt !== 16'h0) begin failures++; $display("FAIL midrst_cnt got=%h/%h exp=0/0", stall_cnt, flush_cnt); end
        tick();
    endtask

    task automatic test_halt_in_dwait;
        apply_reset();
        dreq = 1'b1; dhit = 1'b0;
        tick();
        halt_mem = 1'b1;
        #1;
        checks++; if (freeze !== 4'hF) begin failures++; $display("FAIL dwait_halt_ign got=%h exp=F", freeze); end
        tick();
        dhit = 1'b1;
        #1;
        checks++; if (freeze !== 4'h0 || halt !== 1'b0) begin failures++; $display("FAIL dwait_halt_rel got fr=%h h=%b exp 0/0", freeze, halt); end
        tick();
        dreq = 1'b0; dhit = 1'b0;
        tick();
        halt_mem = 1'b0;
        #1;
        checks++; if (freeze !== 4'b0111) begin failures++; $display("FAIL dwait_halt_drain got=%b exp=0111", freeze); end
        tick();
        #1;
        checks++; if (halt !== 1'b1) begin failures++; $display("FAIL dwait_halt_done got=%b exp=1", halt); end
    endtask

    initial begin
        idle();
        RST = 1'b1;
        test_reset();
        test_dwait_stall();
        test_pend_flush();
        test_ihit_seen();
        test_flush_over_freeze();
        test_reset_mid_dwait();
        test_halt_in_dwait();
        test_halt_and_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
